// File: rtl/decode_stage.sv
// decode_stage -- instruction-decode stage of a five-stage RV32I pipeline.
//
// Decodes InstrD into control signals, generates the sign-extended immediate,
// reads the 32x32 register file (with a same-cycle write-back bypass) and
// registers everything into the ID/EX pipeline register.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   InstrD, PCD, PCPlus4D instruction and its PC / PC+4 from fetch
//   RegWriteW, RDW,       write-back port of the register file
//   ResultW
//   FlushE                bubble the ID/EX register this edge
//   Rs1D, Rs2D            combinational source indices (hazard detection)
//   *E outputs            registered ID/EX contents for the execute stage
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [4:0] rd;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];
  assign rd       = InstrD[11:7];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  // ---------------------------------------------------------------------------
  // Control decode. Defaults are the bubble (all-zero control); only fully
  // recognised opcode/funct3 combinations override them.
  // ---------------------------------------------------------------------------
  logic       reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0] result_src_d;
  logic [2:0] alu_control_d;

  always_comb begin
    reg_write_d   = 1'b0;
    mem_write_d   = 1'b0;
    jump_d        = 1'b0;
    branch_d      = 1'b0;
    alu_src_d     = 1'b0;
    result_src_d  = 2'b00;
    alu_control_d = ALU_ADD;
    unique case (opcode)
      OP_R, OP_I: begin
        // R-type and I-ALU share funct3 encodings; only R-type uses funct7
        // to pick sub over add.
        case (funct3)
          3'b000: begin
            reg_write_d   = 1'b1;
            alu_control_d = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin reg_write_d = 1'b1; alu_control_d = ALU_AND; end
          3'b110: begin reg_write_d = 1'b1; alu_control_d = ALU_OR;  end
          3'b010: begin reg_write_d = 1'b1; alu_control_d = ALU_SLT; end
          default: ;
        endcase
        alu_src_d = reg_write_d && (opcode == OP_I);
      end
      OP_LW: if (funct3 == 3'b010) begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
      end
      OP_SW: if (funct3 == 3'b010) begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_BEQ: if (funct3 == 3'b000) begin
        branch_d      = 1'b1;
        alu_control_d = ALU_SUB;
      end
      OP_JAL: begin
        jump_d       = 1'b1;
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate generation, selected by opcode format.
  // ---------------------------------------------------------------------------
  logic [31:0] imm_ext_d;

  always_comb begin
    imm_ext_d = 32'd0;
    unique case (opcode)
      OP_I, OP_LW: imm_ext_d = {{20{InstrD[31]}}, InstrD[31:20]};
      OP_SW:       imm_ext_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      OP_BEQ:      imm_ext_d = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                                InstrD[11:8], 1'b0};
      OP_JAL:      imm_ext_d = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                                InstrD[30:21], 1'b0};
      default:     imm_ext_d = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file. Entry 0 is held at zero and never written; reads of x0 are
  // forced to zero anyway. A write on the reset edge is suppressed.
  // ---------------------------------------------------------------------------
  logic [31:0] regs [0:31];
  logic        wb_active;

  assign wb_active = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_active) begin
      regs[RDW] <= ResultW;
    end
  end

  logic [31:0] rd1_d, rd2_d;

  always_comb begin
    if (Rs1D == 5'd0)                     rd1_d = 32'd0;
    else if (wb_active && RDW == Rs1D)    rd1_d = ResultW;
    else                                  rd1_d = regs[Rs1D];
    if (Rs2D == 5'd0)                     rd2_d = 32'd0;
    else if (wb_active && RDW == Rs2D)    rd2_d = ResultW;
    else                                  rd2_d = regs[Rs2D];
  end

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register: rst > FlushE > capture. A flush clears control
  // and indices; data fields still capture since nothing downstream uses them
  // in a bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= 3'b000;
      RD1E        <= 32'd0;
      RD2E        <= 32'd0;
      ImmExtE     <= 32'd0;
      PCE         <= 32'd0;
      PCPlus4E    <= 32'd0;
      RdE         <= 5'd0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
    end else begin
      RD1E     <= rd1_d;
      RD2E     <= rd2_d;
      ImmExtE  <= imm_ext_d;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      if (FlushE) begin
        RegWriteE   <= 1'b0;
        MemWriteE   <= 1'b0;
        JumpE       <= 1'b0;
        BranchE     <= 1'b0;
        ALUSrcE     <= 1'b0;
        ResultSrcE  <= 2'b00;
        ALUControlE <= 3'b000;
        RdE         <= 5'd0;
        Rs1E        <= 5'd0;
        Rs2E        <= 5'd0;
      end else begin
        RegWriteE   <= reg_write_d;
        MemWriteE   <= mem_write_d;
        JumpE       <= jump_d;
        BranchE     <= branch_d;
        ALUSrcE     <= alu_src_d;
        ResultSrcE  <= result_src_d;
        ALUControlE <= alu_control_d;
        RdE         <= rd;
        Rs1E        <= Rs1D;
        Rs2E        <= Rs2D;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- directed, self-checking bench for decode_stage.
// Inputs are driven right after a rising edge settles (#1); outputs are
// checked #1 after the next rising edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E),
    .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );

  // Packed control word: {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl}
  logic [9:0] ctrl;
  assign ctrl = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    InstrD = 32'h0000_0013; PCD = 32'd0; PCPlus4D = 32'd4;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0; FlushE = 1'b0;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    RegWriteW = en; RDW = rd; ResultW = data;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    drive(32'h00500093, 32'h100);
    tick(); tick();
    checks++; if (ctrl !== 10'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=000", ctrl); end
    checks++; if ({RD1E, RD2E, ImmExtE, PCE, PCPlus4E} !== 160'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {RD1E, RD2E, ImmExtE, PCE, PCPlus4E}); end
    checks++; if ({RdE, Rs1E, Rs2E} !== 15'd0) begin failures++; $display("FAIL reset_idx got=%h exp=0", {RdE, Rs1E, Rs2E}); end
    rst = 1'b0;
    // Rs1D/Rs2D are combinational: check without a clock edge.
    drive(32'h0062A3B3, 32'h0); #1;
    checks++; if ({Rs1D, Rs2D} !== {5'd5, 5'd6}) begin failures++; $display("FAIL rs_comb got=%0d,%0d exp=5,6", Rs1D, Rs2D); end
  endtask

  task automatic test_addi();
    drive(32'h00500093, 32'h100);   // addi x1,x0,5
    tick();
    checks++; if (ctrl !== {5'b10001, 2'b00, 3'b000}) begin failures++; $display("FAIL addi_ctrl got=%h exp=%h", ctrl, {5'b10001, 2'b00, 3'b000}); end
    checks++; if (ImmExtE !== 32'd5) begin failures++; $display("FAIL addi_imm got=%h exp=5", ImmExtE); end
    checks++; if (RdE !== 5'd1 || RD1E !== 32'd0) begin failures++; $display("FAIL addi_rd got rd=%0d rd1=%h exp rd=1 rd1=0", RdE, RD1E); end
    checks++; if (PCE !== 32'h100 || PCPlus4E !== 32'h104) begin failures++; $display("FAIL addi_pc got=%h/%h exp=100/104", PCE, PCPlus4E); end
  endtask

  task automatic test_bypass_sw();
    drive(32'h0020A423, 32'h104);   // sw x2,8(x1)
    wb(1'b1, 5'd2, 32'hDEADBEEF);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    checks++; if (RD2E !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_bypass got=%h exp=deadbeef", RD2E); end
    checks++; if (ImmExtE !== 32'd8) begin failures++; $display("FAIL sw_imm got=%h exp=8", ImmExtE); end
    checks++; if (ctrl !== {5'b01001, 2'b00, 3'b000}) begin failures++; $display("FAIL sw_ctrl got=%h exp=%h", ctrl, {5'b01001, 2'b00, 3'b000}); end
    // Same instruction again: now from architectural state.
    tick();
    checks++; if (RD2E !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_arch got=%h exp=deadbeef", RD2E); end
  endtask

  task automatic test_beq();
    drive(32'hFE208EE3, 32'h108);   // beq x1,x2,-4
    tick();
    checks++; if (ctrl !== {5'b00010, 2'b00, 3'b001}) begin failures++; $display("FAIL beq_ctrl got=%h exp=%h", ctrl, {5'b00010, 2'b00, 3'b001}); end
    checks++; if (ImmExtE !== 32'hFFFFFFFC) begin failures++; $display("FAIL beq_imm got=%h exp=fffffffc", ImmExtE); end
    checks++; if (Rs1E !== 5'd1 || Rs2E !== 5'd2) begin failures++; $display("FAIL beq_idx got=%0d,%0d exp=1,2", Rs1E, Rs2E); end
  endtask

  task automatic test_jal();
    drive(32'h008000EF, 32'h200);   // jal x1,8
    tick();
    checks++; if (ctrl !== {5'b10100, 2'b10, 3'b000}) begin failures++; $display("FAIL jal_ctrl got=%h exp=%h", ctrl, {5'b10100, 2'b10, 3'b000}); end
    checks++; if (ImmExtE !== 32'd8 || PCPlus4E !== 32'h204) begin failures++; $display("FAIL jal_imm got=%h pc4=%h exp=8/204", ImmExtE, PCPlus4E); end
  endtask

  task automatic test_x0_write();
    drive(32'h000001B3, 32'h300);   // add x3,x0,x0
    wb(1'b1, 5'd0, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    checks++; if (RD1E !== 32'd0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", RD1E); end
    tick();
    checks++; if (RD1E !== 32'd0) begin failures++; $display("FAIL x0_arch got=%h exp=0", RD1E); end
  endtask

  task automatic test_rtype_lw();
    wb(1'b1, 5'd5, 32'd9); tick();
    wb(1'b1, 5'd6, 32'd3); tick();
    wb(1'b0, 5'd0, 32'd0);
    drive(32'h406283B3, 32'h400);   // sub x7,x5,x6
    tick();
    checks++; if (ctrl !== {5'b10000, 2'b00, 3'b001}) begin failures++; $display("FAIL sub_ctrl got=%h exp=%h", ctrl, {5'b10000, 2'b00, 3'b001}); end
    checks++; if (RD1E !== 32'd9 || RD2E !== 32'd3 || ImmExtE !== 32'd0) begin failures++; $display("FAIL sub_data got=%h,%h,%h exp=9,3,0", RD1E, RD2E, ImmExtE); end
    drive(32'h0062A3B3, 32'h404);   // slt x7,x5,x6
    tick();
    checks++; if (ALUControlE !== 3'b101) begin failures++; $display("FAIL slt_alu got=%b exp=101", ALUControlE); end
    drive(32'hFF82A203, 32'h408);   // lw x4,-8(x5)
    tick();
    checks++; if (ctrl !== {5'b10001, 2'b01, 3'b000}) begin failures++; $display("FAIL lw_ctrl got=%h exp=%h", ctrl, {5'b10001, 2'b01, 3'b000}); end
    checks++; if (ImmExtE !== 32'hFFFFFFF8 || RD1E !== 32'd9) begin failures++; $display("FAIL lw_data got imm=%h rd1=%h exp fffffff8/9", ImmExtE, RD1E); end
  endtask

  task automatic test_flush();
    drive(32'h00500093, 32'h500);   // addi x1,x0,5 with flush
    FlushE = 1'b1;
    wb(1'b1, 5'd8, 32'h55);
    tick();
    FlushE = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    checks++; if (ctrl !== 10'd0 || {RdE, Rs1E, Rs2E} !== 15'd0) begin failures++; $display("FAIL flush got ctrl=%h idx=%h exp=0/0", ctrl, {RdE, Rs1E, Rs2E}); end
    drive(32'h000404B3, 32'h504);   // add x9,x8,x0
    tick();
    checks++; if (RD1E !== 32'h55) begin failures++; $display("FAIL flush_wb got=%h exp=55", RD1E); end
  endtask

  task automatic test_bad_decode();
    drive(32'h0000007F, 32'h600);   // unknown opcode
    tick();
    checks++; if (ctrl !== 10'd0) begin failures++; $display("FAIL bad_op got=%h exp=0", ctrl); end
    drive(32'h000011B3, 32'h604);   // R-type funct3=001 (unsupported)
    tick();
    checks++; if (ctrl !== 10'd0 || RdE !== 5'd3) begin failures++; $display("FAIL bad_f3 got ctrl=%h rd=%0d exp=0/3", ctrl, RdE); end
  endtask

  task automatic test_reset_mid();
    // x5 currently holds 9. A write-back on the reset edge must be dropped.
    drive(32'h00528333, 32'h700);   // add x6,x5,x5
    rst = 1'b1;
    wb(1'b1, 5'd5, 32'h77);
    tick();
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'd0);
    checks++; if (ctrl !== 10'd0 || PCE !== 32'd0) begin failures++; $display("FAIL rst_mid_flush got ctrl=%h pc=%h exp=0/0", ctrl, PCE); end
    tick();
    checks++; if (RD1E !== 32'd0 || RD2E !== 32'd0) begin failures++; $display("FAIL rst_mid_regs got=%h,%h exp=0,0", RD1E, RD2E); end
    checks++; if (RegWriteE !== 1'b1 || RdE !== 5'd6) begin failures++; $display("FAIL rst_mid_add got we=%b rd=%0d exp=1/6", RegWriteE, RdE); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_addi();
    test_bypass_sw();
    test_beq();
    test_jal();
    test_x0_write();
    test_rtype_lw();
    test_flush();
    test_bad_decode();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
